inst_fetch_mod: RTL and testbench
=================================

Name: inst_fetch_mod

Overview:
Instruction-byte prefetcher that feeds the control unit.
- Reads opcode and immediate bytes sequentially from the memory bus into a small FIFO.
- Presents the head byte as inst_buffer and pops it when the control unit consumes it.
- Generates the toggle_cb pulses that move the control unit into and out of the CB-prefixed table.
- Flushes and redirects on pc_load (jumps, calls, returns, interrupts).

Parameters:
RESET_PC, 16'h0000, fetch/head address after reset
DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 = held in reset
mem_rd_req  output  1  read request to memory bus
mem_addr  output  16  read address, valid while mem_rd_req=1
mem_rd_ack  input  1  memory returns mem_rd_data this cycle
mem_rd_data  input  8  read byte, sampled when mem_rd_ack=1
inst_buffer  output  8  head byte of FIFO (8'h00 when empty)
inst_valid  output  1  FIFO non-empty
inst_consume  input  1  pop head byte; ignored when inst_valid=0
pc  output  16  address of current head byte
pc_load  input  1  redirect: flush and restart fetch at pc_load_value
pc_load_value  input  16  redirect target
toggle_cb  output  1  one-cycle pulse; control unit inverts CB-table select

Behaviour:
Reset (reset=0, async): all outputs are forced as follows.
- mem_rd_req=0, inst_valid=0, toggle_cb=0.
- pc=RESET_PC, fetch_pc=RESET_PC, mem_addr=RESET_PC.
- FIFO empty, cb_active=0, discard=0, state IDLE.
- Release is synchronous to the first rising edge with reset=1.

Fetch FSM:
- IDLE: if (count + 0) < DEPTH, go to REQ with mem_rd_req=1 and mem_addr=fetch_pc.
- REQ: hold mem_rd_req and mem_addr stable until mem_rd_ack=1.
  - On ack with discard=0: push mem_rd_data and set fetch_pc <= fetch_pc+1 (16-bit wrap, FFFF->0000).
  - On ack with discard=1: drop the byte and clear discard.
  - After ack: stay in REQ at the next address if there is still space after the push (back-to-back, zero bubble); otherwise go to IDLE.
- At most one outstanding request; the bus is never abandoned mid-request.

FIFO:
- Latency: a byte acked at edge N is visible on inst_buffer/inst_valid after edge N.
- No combinational bypass from mem_rd_data to inst_buffer.
- Push and pop in the same cycle: count is unchanged.
- Pop on empty: ignored; no pc change, no toggle.
- Push when full: impossible by construction; asserted in simulation.
- pc increments by 1 (wrapping) on every accepted pop.

CB handling:
- Consume with head=8'hCB and cb_active=0: set cb_active; toggle_cb=1 in the following cycle.
- Consume with cb_active=1: this byte is a CB-table opcode (including 8'hCB itself). Clear cb_active; toggle_cb=1 in the following cycle.
- toggle_cb is registered, exactly one cycle wide per event.

Redirect (pc_load=1):
- Has priority over inst_consume in the same cycle; that consume is dropped.
- Effects at the edge:
  - FIFO empties.
  - pc <= pc_load_value and fetch_pc <= pc_load_value.
  - If in REQ without ack this cycle: set discard=1, and fetch at the new address after the pending ack.
  - If ack occurs in the same cycle as pc_load: drop that byte and re-request at pc_load_value next cycle.
  - If cb_active=1: clear it and pulse toggle_cb next cycle so the control unit stays in sync.
- Back-to-back pc_load: the last one wins; discard stays set until one ack is absorbed.

Decomposition:
- Shared package/include (fetch_defs): CB_PREFIX=8'hCB, ADDR_W=16, DATA_W=8, fetch FSM state encodings (IDLE, REQ).
- Sub-module fetch_fifo_mod: parameterised DEPTH x 8 synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head, count, empty, full.
  - Async active-low reset.
- The FSM, pc/fetch_pc registers and CB logic stay in inst_fetch_mod.

Test Plan:
1. Sequential fill: release reset with RESET_PC=0100, memory acks every cycle (bytes 00,3E,12,C3), no consume. Required: requests at 0100..0103; mem_rd_req drops after the 4th ack; inst_buffer=00, inst_valid=1, pc=0100.
2. Stall handshake: ack delayed 3 cycles. Required: mem_addr held at 0100 with mem_rd_req=1 throughout; one push only; inst_buffer=byte after ack.
3. CB sequence: bytes CB,CB,00 consumed one per cycle. Required: toggle_cb pulses after the 1st and 2nd consumes only; cb_active ends at 0; pc advances by 3.
4. Redirect mid-request: pc_load=1 with pc_load_value=2000 while a request to 0105 is pending. Required:
   - FIFO empties and pc=2000.
   - The late ack byte is discarded.
   - The next request has mem_addr=2000.
   - A pc_load during cb_active=1 yields one toggle_cb pulse.
5. Wrap and edges: fetch_pc=FFFF, ack. Required: next mem_addr=0000. Also:
   - inst_consume with an empty FIFO: no pc change, no toggle.
   - Simultaneous push and pop with count=DEPTH-1: count unchanged.
   - Async reset asserted mid-REQ: mem_rd_req=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/inst_fetch_mod_pkg.sv
// Shared definitions for the instruction prefetcher: bus widths, the CB
// prefix opcode and the fetch FSM state encoding.
package fetch_defs;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] CB_PREFIX = 8'hCB;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_t;

   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + 1'b1;
   endfunction

endpackage

// File: rtl/fetch_fifo_mod.sv
// DEPTH x 8 synchronous FIFO holding prefetched instruction bytes.
// The head entry is read combinationally so a push is visible right after its edge.
module fetch_fifo_mod
   import fetch_defs::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full
);

   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [DATA_W-1:0] entry_arr [DEPTH];
   logic              push_ok;
   logic              pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign push_ok = push & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DATA_W-1:0] entry_reg;
         always_ff @(posedge clock or negedge reset) begin
            if (!reset)
               entry_reg <= '0;
            else if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
               entry_reg <= wr_data;
         end
         assign entry_arr[gi] = entry_reg;
      end
   endgenerate

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = empty ? '0 : entry_arr[rd_ptr_reg];
   assign count = count_reg;

   a_no_overflow : assert property (@(posedge clock) disable iff (!reset)
      !(push && full && !flush));

endmodule

// File: rtl/inst_fetch_mod.sv
// Instruction-byte prefetcher: fetches sequential bytes into a FIFO, tracks
// the head pc, signals CB-table entry/exit and redirects on pc_load.
module inst_fetch_mod
   import fetch_defs::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_rd_req,
   output logic [15:0] mem_addr,
   input  logic        mem_rd_ack,
   input  logic [7:0]  mem_rd_data,
   output logic [7:0]  inst_buffer,
   output logic        inst_valid,
   input  logic        inst_consume,
   output logic [15:0] pc,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   output logic        toggle_cb
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
   logic              discard_reg, discard_next;
   logic              cb_active_reg, cb_active_next;
   logic              toggle_reg, toggle_next;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              ack_take;

   // A redirect outranks a consume, so the dropped consume never pops.
   assign fifo_pop  = inst_consume & ~fifo_empty & ~pc_load;
   assign ack_take  = (state_reg == ST_REQ) & mem_rd_ack;
   assign fifo_push = ack_take & ~discard_reg & ~pc_load;

   fetch_fifo_mod #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (pc_load),
      .wr_data (mem_rd_data),
      .head    (fifo_head),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         fetch_pc_reg  <= RESET_PC;
         pc_reg        <= RESET_PC;
         req_addr_reg  <= RESET_PC;
         discard_reg   <= 1'b0;
         cb_active_reg <= 1'b0;
         toggle_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         fetch_pc_reg  <= fetch_pc_next;
         pc_reg        <= pc_next;
         req_addr_reg  <= req_addr_next;
         discard_reg   <= discard_next;
         cb_active_reg <= cb_active_next;
         toggle_reg    <= toggle_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      fetch_pc_next  = fetch_pc_reg;
      pc_next        = pc_reg;
      req_addr_next  = req_addr_reg;
      discard_next   = discard_reg;
      cb_active_next = cb_active_reg;
      toggle_next    = 1'b0;

      if (fifo_pop) begin
         pc_next = addr_inc(pc_reg);
         if (cb_active_reg) begin
            cb_active_next = 1'b0;
            toggle_next    = 1'b1;
         end else if (fifo_head == CB_PREFIX) begin
            cb_active_next = 1'b1;
            toggle_next    = 1'b1;
         end
      end

      // Leaving the CB table on a redirect keeps the control unit in step.
      if (pc_load) begin
         pc_next       = pc_load_value;
         fetch_pc_next = pc_load_value;
         if (cb_active_reg) begin
            cb_active_next = 1'b0;
            toggle_next    = 1'b1;
         end
      end

      case (state_reg)
         ST_IDLE: begin
            if (pc_load || fifo_pop || !fifo_full) begin
               state_next    = ST_REQ;
               req_addr_next = fetch_pc_next;
            end
         end
         ST_REQ: begin
            if (mem_rd_ack) begin
               discard_next = 1'b0;
               if (pc_load || discard_reg) begin
                  req_addr_next = fetch_pc_next;
               end else begin
                  fetch_pc_next = addr_inc(fetch_pc_reg);
                  // Room remains after this push: keep fetching with no bubble.
                  if ((fifo_count < CNT_W'(DEPTH - 1)) || fifo_pop)
                     req_addr_next = addr_inc(fetch_pc_reg);
                  else
                     state_next = ST_IDLE;
               end
            end else if (pc_load) begin
               discard_next = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign mem_rd_req  = (state_reg == ST_REQ);
   assign mem_addr    = req_addr_reg;
   assign inst_buffer = fifo_head;
   assign inst_valid  = ~fifo_empty;
   assign pc          = pc_reg;
   assign toggle_cb   = toggle_reg;

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Directed bench for inst_fetch_mod with a programmable-latency memory responder.
`timescale 1ns/1ps
module tb_inst_fetch_mod;

   logic        clock;
   logic        reset;
   logic        mem_rd_req;
   logic [15:0] mem_addr;
   logic        mem_rd_ack;
   logic [7:0]  mem_rd_data;
   logic [7:0]  inst_buffer;
   logic        inst_valid;
   logic        inst_consume;
   logic [15:0] pc;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic        toggle_cb;

   int total = 0;
   int bad   = 0;
   int ack_delay = 0;
   int wait_cnt  = 0;
   bit auto_en   = 1'b1;

   inst_fetch_mod #(
      .RESET_PC (16'h0100),
      .DEPTH    (4)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_rd_req    (mem_rd_req),
      .mem_addr      (mem_addr),
      .mem_rd_ack    (mem_rd_ack),
      .mem_rd_data   (mem_rd_data),
      .inst_buffer   (inst_buffer),
      .inst_valid    (inst_valid),
      .inst_consume  (inst_consume),
      .pc            (pc),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .toggle_cb     (toggle_cb)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      case (a)
         16'h0100: return 8'h00;
         16'h0101: return 8'h3E;
         16'h0102: return 8'h12;
         16'h0103: return 8'hC3;
         16'h0104: return 8'hCB;
         16'h0105: return 8'hCB;
         16'h0106: return 8'h00;
         16'h2000: return 8'h77;
         16'h2001: return 8'hCB;
         16'hFFFF: return 8'h5A;
         16'h0000: return 8'hA5;
         default:  return a[7:0] ^ a[15:8];
      endcase
   endfunction

   // Memory responder: acks a pending request after ack_delay idle cycles.
   initial begin
      mem_rd_ack  = 1'b0;
      mem_rd_data = 8'h00;
      forever begin
         @(posedge clock);
         #1;
         if (auto_en && mem_rd_req) begin
            if (wait_cnt >= ack_delay) begin
               mem_rd_ack  = 1'b1;
               mem_rd_data = mem_byte(mem_addr);
               wait_cnt    = 0;
            end else begin
               mem_rd_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_rd_ack = 1'b0;
            wait_cnt   = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   logic [15:0] t3_pc   [6] = '{16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
   logic [15:0] t3_buf  [6] = '{16'h0012, 16'h00C3, 16'h00CB, 16'h00CB, 16'h0000, 16'h0006};
   logic [15:0] t3_tog  [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
   logic [15:0] t3_addr [6] = '{16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109, 16'h010A};

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      inst_consume  = 1'b0;
      pc_load       = 1'b0;
      pc_load_value = 16'h0000;
      step();
      step();
      chk("rst_req",   16'(mem_rd_req), 16'h0000);
      chk("rst_valid", 16'(inst_valid), 16'h0000);
      chk("rst_tog",   16'(toggle_cb),  16'h0000);
      chk("rst_pc",    pc,              16'h0100);
      chk("rst_addr",  mem_addr,        16'h0100);
      chk("rst_buf",   16'(inst_buffer), 16'h0000);

      // Sequential fill, ack every cycle.
      reset = 1'b1;
      step();
      chk("fill_req0",  16'(mem_rd_req), 16'h0001);
      chk("fill_addr0", mem_addr,        16'h0100);
      for (int i = 1; i < 4; i++) begin
         step();
         chk("fill_addr", mem_addr, 16'(16'h0100 + i));
         chk("fill_buf",  16'(inst_buffer), 16'h0000);
      end
      step();
      chk("fill_req_drop", 16'(mem_rd_req),  16'h0000);
      chk("fill_valid",    16'(inst_valid),  16'h0001);
      chk("fill_buf_end",  16'(inst_buffer), 16'h0000);
      chk("fill_pc",       pc,               16'h0100);

      // Stall handshake: ack arrives after 3 idle cycles.
      ack_delay    = 3;
      inst_consume = 1'b1;
      step();
      inst_consume = 1'b0;
      chk("stall_pc",   pc,               16'h0101);
      chk("stall_buf",  16'(inst_buffer), 16'h003E);
      chk("stall_addr", mem_addr,         16'h0104);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold_req",  16'(mem_rd_req), 16'h0001);
         chk("stall_hold_addr", mem_addr,        16'h0104);
      end
      step();
      chk("stall_req_drop", 16'(mem_rd_req),          16'h0000);
      chk("stall_count",    16'(dut.u_fifo.count_reg), 16'h0004);
      chk("stall_buf2",     16'(inst_buffer),         16'h003E);
      ack_delay = 0;

      // Drain 3E,12,C3 then consume CB,CB,00.
      inst_consume = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("cb_pc",   pc,               t3_pc[i]);
         chk("cb_buf",  16'(inst_buffer), t3_buf[i]);
         chk("cb_tog",  16'(toggle_cb),   t3_tog[i]);
         chk("cb_addr", mem_addr,         t3_addr[i]);
         if (i == 4)
            ack_delay = 3;
      end
      inst_consume = 1'b0;

      // Redirect while the request to 010A is pending.
      step();
      chk("rd_pend_addr", mem_addr, 16'h010A);
      pc_load       = 1'b1;
      pc_load_value = 16'h2000;
      step();
      pc_load = 1'b0;
      chk("rd_valid",     16'(inst_valid),  16'h0000);
      chk("rd_buf",       16'(inst_buffer), 16'h0000);
      chk("rd_pc",        pc,               16'h2000);
      chk("rd_addr_hold", mem_addr,         16'h010A);
      chk("rd_no_tog",    16'(toggle_cb),   16'h0000);
      step();
      chk("rd_wait_addr", mem_addr, 16'h010A);
      step();
      chk("rd_discard_valid", 16'(inst_valid), 16'h0000);
      chk("rd_new_addr",      mem_addr,        16'h2000);
      ack_delay = 0;
      step();
      chk("rd_new_addr2", mem_addr, 16'h2000);
      step();
      chk("rd_first_buf", 16'(inst_buffer), 16'h0077);
      chk("rd_first_pc",  pc,               16'h2000);
      chk("rd_next_addr", mem_addr,         16'h2001);

      // Redirect while in the CB table, ack in the same cycle.
      inst_consume = 1'b1;
      step();
      chk("cbrd_buf", 16'(inst_buffer), 16'h00CB);
      step();
      chk("cbrd_enter_tog", 16'(toggle_cb), 16'h0001);
      chk("cbrd_pc",        pc,             16'h2002);
      inst_consume  = 1'b0;
      pc_load       = 1'b1;
      pc_load_value = 16'h0300;
      step();
      pc_load = 1'b0;
      chk("cbrd_exit_tog", 16'(toggle_cb),  16'h0001);
      chk("cbrd_valid",    16'(inst_valid), 16'h0000);
      chk("cbrd_addr",     mem_addr,        16'h0300);
      step();
      chk("cbrd_tog_once", 16'(toggle_cb),   16'h0000);
      chk("cbrd_buf2",     16'(inst_buffer), 16'h0003);

      // Address wrap FFFF -> 0000.
      pc_load       = 1'b1;
      pc_load_value = 16'hFFFF;
      step();
      pc_load = 1'b0;
      chk("wrap_addr0", mem_addr, 16'hFFFF);
      chk("wrap_pc0",   pc,       16'hFFFF);
      step();
      chk("wrap_addr",  mem_addr,         16'h0000);
      chk("wrap_buf",   16'(inst_buffer), 16'h005A);
      inst_consume = 1'b1;
      step();
      chk("wrap_pc",    pc,               16'h0000);
      chk("wrap_buf2",  16'(inst_buffer), 16'h00A5);
      inst_consume = 1'b0;
      auto_en      = 1'b0;
      step();
      chk("drain_addr", mem_addr, 16'h0002);

      // Drain, then consume on an empty FIFO.
      inst_consume = 1'b1;
      step();
      chk("drain_pc1", pc, 16'h0001);
      step();
      chk("drain_pc2",   pc,              16'h0002);
      chk("drain_empty", 16'(inst_valid), 16'h0000);
      step();
      chk("empty_pc",  pc,              16'h0002);
      chk("empty_tog", 16'(toggle_cb),  16'h0000);
      inst_consume = 1'b0;
      auto_en      = 1'b1;

      // Simultaneous push and pop at count = DEPTH-1.
      step();
      chk("pp_req_addr", mem_addr, 16'h0002);
      step();
      step();
      step();
      chk("pp_count_pre", 16'(dut.u_fifo.count_reg), 16'h0003);
      inst_consume = 1'b1;
      step();
      inst_consume = 1'b0;
      auto_en      = 1'b0;
      chk("pp_count", 16'(dut.u_fifo.count_reg), 16'h0003);
      chk("pp_pc",    pc,                       16'h0003);
      chk("pp_buf",   16'(inst_buffer),         16'h0003);
      chk("pp_addr",  mem_addr,                 16'h0006);
      chk("pp_req",   16'(mem_rd_req),          16'h0001);

      // Asynchronous reset in the middle of a request.
      #1;
      reset = 1'b0;
      #1;
      chk("areset_req",   16'(mem_rd_req), 16'h0000);
      chk("areset_valid", 16'(inst_valid), 16'h0000);
      chk("areset_pc",    pc,              16'h0100);
      chk("areset_addr",  mem_addr,        16'h0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
